// File: rtl/mem_port_ctrl.sv
//==============================================================================
// Module   : mem_port_ctrl
// Purpose  : Multicycle memory-access stage between the control FSM and a
//            variable-latency unified memory. Selects the access address
//            (pc or alu_out), runs a req/ack handshake, captures read data
//            into the instruction register and the MDR, and stalls the
//            control FSM until the access completes.
// Option   : MEMIF_TIMEOUT_EN - when defined, a BUSY watchdog moves to a
//            terminal ERR state after TIMEOUT cycles without mem_ack.
// Ports    : clk, rset_n           clock / async active-low reset
//            MemRead, MemWrite     access requests from control FSM
//            IorD                  address select (0=pc, 1=alu_out)
//            IRwrite               read data also loads instr
//            pc, alu_out, wdata    address sources and store data
//            mem_req/we/addr/wdata memory request side (held until ack)
//            mem_rdata, mem_ack    memory response side
//            instr, mdr            captured read data (op = instr[31:26])
//            stall, err            FSM hold and sticky error flag
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rset_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRwrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   ir_ld;
  logic   req_ok;
  logic   req_bad;
  logic   timeout_hit;

  // Exactly one of read/write starts an access; both at once is illegal.
  assign req_ok  = MemRead ^ MemWrite;
  assign req_bad = MemRead & MemWrite;

`ifdef MEMIF_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] to_cnt;

  // Counter is zero on every BUSY entry because it is held clear in IDLE.
  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) begin
      to_cnt <= '0;
    end else if (state == S_IDLE) begin
      to_cnt <= '0;
    end else if (state == S_BUSY && !mem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires on the BUSY cycle whose increment reaches TIMEOUT, i.e. after
  // TIMEOUT ack-less BUSY cycles. An ack in that same cycle wins.
  assign timeout_hit = (state == S_BUSY) && !mem_ack &&
                       (({1'b0, to_cnt} + 1'b1) == (CNT_W + 1)'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        stall = req_ok;
        if (req_ok) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
        end
      end
      // DONE releases the FSM for one cycle and ignores still-held requests
      // so the same access is not issued twice.
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
    // Keep stall low while reset is asserted, whatever the request inputs.
    if (!rset_n) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instr     <= '0;
      mdr       <= '0;
      err       <= 1'b0;
      ir_ld     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            mem_addr  <= IorD ? alu_out : pc;
            mem_wdata <= wdata;
            mem_we    <= MemWrite;
            ir_ld     <= IRwrite & MemRead;
            mem_req   <= 1'b1;
          end else if (req_bad) begin
            err <= 1'b1;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              mdr <= mem_rdata;
              if (ir_ld) begin
                instr <= mem_rdata;
              end
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
//==============================================================================
// Module   : tb_mem_port_ctrl
// Purpose  : Self-checking bench for mem_port_ctrl. Directed fetch/load/store,
//            held-request, illegal-request and reset cases, then randomized
//            accesses against a transaction-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rset_n;
  logic          MemRead, MemWrite, IorD, IRwrite;
  logic [AW-1:0] pc, alu_out;
  logic [DW-1:0] wdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] instr, mdr;
  logic          stall, err;

  mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rset_n(rset_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRwrite(IRwrite),
    .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr(instr), .mdr(mdr), .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the architectural registers should hold.
  logic [DW-1:0] mdr_m, instr_m;
  logic          err_m;

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRwrite  = 1'b0;
  endtask

  // One complete access. lat = number of BUSY cycles until ack (>=1).
  // hold keeps the request asserted through DONE to prove no re-issue.
  task automatic run_access(input logic rd, input logic wr, input logic iord,
                            input logic irw, input logic [AW-1:0] pcv,
                            input logic [AW-1:0] aluv, input logic [DW-1:0] wdv,
                            input logic [DW-1:0] rv, input int lat,
                            input bit hold);
    logic [AW-1:0] addr_e;
    int            stall_cnt;
    addr_e = iord ? aluv : pcv;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; IorD = iord; IRwrite = irw;
    pc = pcv; alu_out = aluv; wdata = wdv;
    #1;
    check_eq("stall_idle", stall, rd ^ wr);
    if (rd && wr) begin
      @(posedge clk); #1;
      err_m = 1'b1;
      check_eq("illegal_err", err, err_m);
      check_eq("illegal_req", mem_req, 1'b0);
      check_eq("illegal_stall", stall, 1'b0);
      @(negedge clk); idle_inputs();
      #1 check_eq("illegal_req2", mem_req, 1'b0);
      return;
    end
    if (!rd && !wr) return;
    stall_cnt = 1;
    @(posedge clk); #1;
    check_eq("req_rise", mem_req, 1'b1);
    check_eq("addr", mem_addr, addr_e);
    check_eq("we", mem_we, wr);
    check_eq("wdata_lat", mem_wdata, wdv);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      wdata = $urandom;
      pc = $urandom;
      alu_out = $urandom;
      if (k == lat) begin
        mem_ack = 1'b1;
        mem_rdata = rv;
      end else begin
        mem_rdata = $urandom;
      end
      #1;
      check_eq("stall_busy", stall, 1'b1);
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      if (k < lat) begin
        check_eq("req_hold", mem_req, 1'b1);
        check_eq("addr_hold", mem_addr, addr_e);
        check_eq("wdata_hold", mem_wdata, wdv);
        check_eq("we_hold", mem_we, wr);
      end
    end
    if (rd) begin
      mdr_m = rv;
      if (irw) instr_m = rv;
    end
    check_eq("req_drop", mem_req, 1'b0);
    check_eq("stall_done", stall, 1'b0);
    check_eq("mdr", mdr, mdr_m);
    check_eq("instr", instr, instr_m);
    check_eq("stall_cycles", stall_cnt, lat + 1);
    @(negedge clk);
    mem_ack = 1'b0;
    if (!hold) idle_inputs();
    @(posedge clk); #1;
    check_eq("no_reissue", mem_req, 1'b0);
    check_eq("stall_after", stall, hold);
    @(negedge clk); idle_inputs();
    check_eq("err_keep", err, err_m);
  endtask

  task automatic stray_ack();
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    @(posedge clk); #1;
    check_eq("stray_mdr", mdr, mdr_m);
    check_eq("stray_instr", instr, instr_m);
    check_eq("stray_req", mem_req, 1'b0);
    @(negedge clk); mem_ack = 1'b0;
  endtask

  task automatic reset_model();
    mdr_m = '0; instr_m = '0; err_m = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, mem_req, 1'b0);
    check_eq({tag, "_we"}, mem_we, 1'b0);
    check_eq({tag, "_addr"}, mem_addr, '0);
    check_eq({tag, "_wdata"}, mem_wdata, '0);
    check_eq({tag, "_mdr"}, mdr, '0);
    check_eq({tag, "_instr"}, instr, '0);
    check_eq({tag, "_stall"}, stall, 1'b0);
    check_eq({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rd, wr;
    int   sel;
    rset_n = 1'b0;
    idle_inputs();
    IorD = 1'b0; pc = '0; alu_out = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    reset_model();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rset_n = 1'b1;

    // Fetch with request held through DONE.
    run_access(1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h8C220004, 3, 1'b1);
    // Load, ack in first BUSY cycle; instr must not change.
    run_access(1, 0, 1, 0, 32'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
    // Store; wdata scrambled mid-BUSY; mdr/instr untouched.
    run_access(0, 1, 1, 0, 32'h0, 32'h104, 32'h12345678, 32'hCAFEF00D, 3, 1'b0);
    stray_ack();
    // Illegal request: err set, no transaction.
    run_access(1, 1, 0, 1, 32'h80, 32'h200, 32'h5, 32'h0, 1, 1'b0);
    run_access(1, 0, 0, 1, 32'h44, 32'h0, 32'h0, 32'h01234567, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      rd = (sel < 4) || (sel == 7);
      wr = (sel >= 4);
      run_access(rd, wr, 1'($urandom), 1'($urandom), $urandom, $urandom,
                 $urandom, $urandom, $urandom_range(1, TO), 1'($urandom));
      if ((i % 8) == 3) stray_ack();
    end

    // Reset asserted mid-BUSY, away from a clock edge.
    @(negedge clk);
    MemRead = 1'b1; IorD = 1'b1; alu_out = 32'h300;
    @(posedge clk); #1;
    check_eq("rst_pre_req", mem_req, 1'b1);
    @(negedge clk); #2;
    rset_n = 1'b0;
    #1;
    reset_model();
    check_reset_outputs("rst_busy");
    @(negedge clk); idle_inputs(); rset_n = 1'b1;
    stray_ack();

`ifdef MEMIF_TIMEOUT_EN
    // Watchdog: no ack, ERR after TO BUSY cycles.
    @(negedge clk);
    MemRead = 1'b1; IorD = 1'b0; pc = 32'h500;
    @(posedge clk); #1;
    check_eq("to_req", mem_req, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk); #1;
      check_eq("to_stall", stall, 1'b1);
      @(posedge clk); #1;
      if (k < TO) check_eq("to_wait_req", mem_req, 1'b1);
    end
    err_m = 1'b1;
    check_eq("to_err", err, err_m);
    check_eq("to_req_drop", mem_req, 1'b0);
    check_eq("to_stall_err", stall, 1'b0);
    stray_ack();
    @(posedge clk); #1;
    check_eq("to_err_ignored", mem_req, 1'b0);
    @(negedge clk); #2;
    rset_n = 1'b0;
    #1;
    reset_model();
    check_reset_outputs("rst_err");
    @(negedge clk); idle_inputs(); rset_n = 1'b1;
    stray_ack();
`endif

    run_access(1, 0, 0, 1, 32'h48, 32'h0, 32'h0, 32'h2402000A, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
